// File: rtl/output_serializer_pkg.sv
// Shared constants for the output serializer: FSM encodings, default geometry
// and a small width helper used by the serializer and its interface.
`ifndef OUTPUT_SERIALIZER_PKG_SV
`define OUTPUT_SERIALIZER_PKG_SV

package output_serializer_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_t;

  localparam int DEF_DATA_WIDTH    = 4;
  localparam int DEF_WORDS_PER_BUS = 4;
  localparam int DEF_FIFO_DEPTH    = 4;

  // Index width that stays at least one bit even for a single-lane word.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`endif

// File: rtl/output_serializer_if.sv
// Bus bundle between the upstream data selector, the serializer and the
// downstream nibble consumer.
interface output_serializer_if #(
  parameter int DATA_WIDTH    = 4,
  parameter int WORDS_PER_BUS = 4,
  parameter int FIFO_DEPTH    = 4
);
  localparam int W  = DATA_WIDTH * WORDS_PER_BUS;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Upstream pushes a word whenever data_in_valid=1 (no ready; wBusy is an
  // early-warning backpressure hint). Downstream transfers a nibble on every
  // rising edge where nibble_valid=1 and nibble_ready=1; while nibble_valid=1
  // and nibble_ready=0, nibble_out and word_last hold stable.
  logic [W-1:0]          data_in;
  logic                  data_in_valid;
  logic                  wBusy;
  logic [DATA_WIDTH-1:0] nibble_out;
  logic                  nibble_valid;
  logic                  nibble_ready;
  logic                  word_last;
  logic                  overflow;
  logic [CW-1:0]         count;

  modport master (
    output data_in, data_in_valid, nibble_ready,
    input  wBusy, nibble_out, nibble_valid, word_last, overflow, count
  );

  modport slave (
    input  data_in, data_in_valid, nibble_ready,
    output wBusy, nibble_out, nibble_valid, word_last, overflow, count
  );

endinterface

// File: rtl/output_serializer_fifo.sv
// sync_word_fifo: single-clock word FIFO with occupancy count; full/empty are
// decoded from the count so wrapped pointers never alias.
module sync_word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_acc  = rd_en && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_acc  = wr_en && (!full || rd_acc);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc)      count <= count + 1'b1;
      else if (!wr_acc && rd_acc) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/output_serializer.sv
// Buffers upstream words in a small FIFO and streams each one out LSB lane
// first, back-to-back across words, with a sticky overflow flag.
module output_serializer
  import output_serializer_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int WORDS_PER_BUS = DEF_WORDS_PER_BUS,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  output_serializer_if.slave  bus,
  output ser_state_t          dbg_state
);
  localparam int W  = DATA_WIDTH * WORDS_PER_BUS;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = width_min1(WORDS_PER_BUS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS_PER_BUS - 1);

  ser_state_t            state;
  logic [W-1:0]          shift_reg;
  logic [W-1:0]          head;
  logic [IW-1:0]         index;
  logic [IW-1:0]         next_index;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  lane_last;
  logic                  pop;
  logic                  drop;
  logic [DATA_WIDTH-1:0] nibble_q;
  logic                  valid_q;
  logic                  last_q;
  logic                  overflow_q;

  assign lane_last  = (index == LAST_IDX);
  assign next_index = index + 1'b1;

  // Pop from IDLE, or exactly when the final lane is handed off, so words
  // follow each other without a bubble.
  assign pop  = !fifo_empty &&
                ((state == S_IDLE) ||
                 (state == S_SEND && bus.nibble_ready && lane_last));
  assign drop = bus.data_in_valid && fifo_full && !pop;

  sync_word_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.data_in_valid),
    .wr_data (bus.data_in),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      shift_reg  <= '0;
      index      <= '0;
      nibble_q   <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (drop) overflow_q <= 1'b1;

      if (pop) begin
        state     <= S_SEND;
        shift_reg <= head;
        index     <= '0;
        nibble_q  <= head[DATA_WIDTH-1:0];
        valid_q   <= 1'b1;
        last_q    <= (LAST_IDX == '0);
      end else if (state == S_SEND && bus.nibble_ready) begin
        if (lane_last) begin
          state   <= S_IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end else begin
          index    <= next_index;
          nibble_q <= shift_reg[next_index*DATA_WIDTH +: DATA_WIDTH];
          last_q   <= (next_index == LAST_IDX);
        end
      end
    end
  end

  // One slot of headroom covers the word already in the upstream register.
  assign bus.wBusy        = (fifo_count >= CW'(FIFO_DEPTH - 1));
  assign bus.count        = fifo_count;
  assign bus.nibble_out   = nibble_q;
  assign bus.nibble_valid = valid_q;
  assign bus.word_last    = last_q;
  assign bus.overflow     = overflow_q;
  assign dbg_state        = state;

endmodule

// File: doc/output_serializer.md
OUTPUT_SERIALIZER -- requirements
Module: output_serializer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 4, giving the nibble (lane) width in bits.
REQ-002 The module SHALL have parameter WORDS_PER_BUS, default 4, giving the lanes per input word; input width W = DATA_WIDTH*WORDS_PER_BUS.
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 4, giving the word FIFO depth; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  W  word from the upstream data selector's registered output.
REQ-007 data_in_valid  input  1  data_in carries a word this cycle.
REQ-008 wBusy  output  1  backpressure to the upstream selector.
REQ-009 nibble_out  output  DATA_WIDTH  current serialized lane.
REQ-010 nibble_valid  output  1  nibble_out is valid.
REQ-011 nibble_ready  input  1  downstream accepts nibble_out this cycle.
REQ-012 word_last  output  1  nibble_out is the final lane of its word.
REQ-013 overflow  output  1  sticky flag: a word was dropped.
REQ-014 count  output  $clog2(FIFO_DEPTH+1)  words held in the FIFO, excluding the word being serialized.

Function
REQ-015 Write: on a rising edge with data_in_valid=1 and the FIFO not full, data_in SHALL be stored; count +1 unless a pop occurs in the same cycle.
REQ-016 Full with pop in the same cycle: the write SHALL be accepted and count SHALL stay at FIFO_DEPTH.
REQ-017 Full without pop: the word SHALL be dropped, overflow SHALL set to 1, and overflow SHALL hold until reset.
REQ-018 wBusy SHALL be 1 when count >= FIFO_DEPTH-1. This leaves one slot for the word already in flight in the upstream one-cycle output register.
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be derived from count, not from pointer equality alone.
REQ-020 The serializer FSM SHALL have states IDLE and SEND.
REQ-021 IDLE: nibble_valid=0. If count>0, the FSM SHALL pop the head word into the shift register, set lane index to 0, and enter SEND on the next edge.
REQ-022 SEND: nibble_valid=1 and nibble_out = shift_reg[index*DATA_WIDTH +: DATA_WIDTH]. Lane order is LSB first.
REQ-023 SEND with nibble_ready=1 and index<WORDS_PER_BUS-1: index SHALL increment.
REQ-024 SEND with nibble_ready=0: nibble_out, word_last and index SHALL hold stable.
REQ-025 word_last SHALL be 1 exactly when in SEND and index = WORDS_PER_BUS-1.
REQ-026 Last lane accepted with count>0: the next word SHALL be popped in the same cycle and SEND retained with index 0. No bubble between words.
REQ-027 Last lane accepted with count=0: the FSM SHALL return to IDLE.
REQ-028 A word written into an empty FIFO while in IDLE SHALL appear on nibble_out two edges after its write edge. Its lane 0 is valid in the cycle after the pop edge.
REQ-029 All outputs SHALL be registered or decoded only from state/registers. No combinational path from data_in to nibble_out.

Reset
REQ-030 When rst=0, asynchronously: FSM SHALL be IDLE; pointers, count, index and shift register SHALL be 0; nibble_valid, word_last, wBusy and overflow SHALL be 0; nibble_out SHALL be 0.
REQ-031 Reset mid-word SHALL discard the partial word and all FIFO contents; no lane SHALL be emitted for them after release.
REQ-032 Release SHALL take effect on the first rising clk edge after rst returns to 1.

Structure
REQ-033 FSM state encodings (IDLE=0, SEND=1) SHALL live in the shared defines file, under an include guard, alongside the other block-level constants.
REQ-034 The word FIFO SHALL be a separate sub-module, sync_word_fifo, parameterized by width and depth, exposing count, full and empty.
REQ-035 The module SHALL be instantiable directly after data_selector, with data_in tied to its data_out and wBusy fed back to its wBusy input.

Verification
REQ-036 Single word: write 16'hA5C3 into an empty FIFO with nibble_ready=1 -> nibble_out 3,C,5,A on consecutive cycles; word_last=1 only with A; then IDLE.
REQ-037 Back-to-back: write 16'h1234 then 16'h5678 on consecutive cycles, nibble_ready=1 -> 8 nibbles 4,3,2,1,8,7,6,5 with no gap.
REQ-038 Stall: nibble_ready=0 for 3 cycles at lane 2 of 16'hBEEF -> nibble_out holds E; sequence completes F,E,E,B once ready returns.
REQ-039 Fill with nibble_ready=0 (FIFO_DEPTH=4): 6 writes -> wBusy=1 once count=3; 1 word held in the shift register and 4 in the FIFO; 6th write dropped and overflow=1.
REQ-040 Full with pop: FIFO full, last lane accepted in the same cycle as a write -> write accepted, count stays 4, overflow stays 0.
REQ-041 Reset mid-word: assert rst low during lane 1 -> outputs 0 immediately; after release, no nibbles until a new write.
